// File: rtl/seg7_scan_counter_pkg.sv
// Shared constants for the BCD scan counter.
// Holds the active-high 7-segment patterns ({g,f,e,d,c,b,a}), the nibble and
// segment widths, the per-cycle counter operation type and a BCD clamp helper.
package seg7_scan_counter_pkg;

  localparam int BCD_W = 4;
  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0    = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1    = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2    = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3    = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4    = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5    = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6    = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7    = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8    = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9    = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_DARK = 7'h00;

  // What the counter does on the coming edge (reset is handled separately).
  typedef enum logic [1:0] {
    OP_HOLD,
    OP_LOAD,
    OP_STEP
  } cnt_op_e;

  // Non-decimal nibbles saturate at 9 so the counter only ever holds BCD.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

endpackage

// File: rtl/seg7_scan_counter_if.sv
// Control/display bundle of the BCD scan counter.
// master: switches/control side (drives inhibit, up_down, load, load_value,
//         lzb_en; observes count, wrap, seg, sel, hex_flat).
// slave : the counter itself.
interface seg7_scan_counter_if
  import seg7_scan_counter_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);

  logic                          inhibit;
  logic                          up_down;
  logic                          load;
  logic [BCD_W*NUM_DIGITS-1:0]   load_value;
  logic                          lzb_en;
  logic [BCD_W*NUM_DIGITS-1:0]   count;
  logic                          wrap;
  logic [SEG_W-1:0]              seg;
  logic [NUM_DIGITS-1:0]         sel;
  logic [SEG_W*NUM_DIGITS-1:0]   hex_flat;

  modport master (
    output inhibit, up_down, load, load_value, lzb_en,
    input  count, wrap, seg, sel, hex_flat
  );

  modport slave (
    input  inhibit, up_down, load, load_value, lzb_en,
    output count, wrap, seg, sel, hex_flat
  );

endinterface

// File: rtl/seg7_scan_counter_decode.sv
// seg7_decode: combinational BCD nibble to active-high 7-segment pattern.
// Ports: bcd (4-bit digit in), seg ({g,f,e,d,c,b,a}, 1 = lit). Values above 9
// produce a dark digit.
module seg7_decode
  import seg7_scan_counter_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_DARK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DARK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_counter.sv
// seg7_scan_counter: N-digit BCD up/down counter with prescaler, parallel load
// and wrap pulse, plus a multiplexed 7-segment scanner (blanking at the start
// of every slot, optional leading-zero blanking) and static per-digit codes.
// Ports:
//   CLOCK_50 - system clock, rising edge
//   reset    - synchronous, active-high
//   bus      - slave side of seg7_scan_counter_if (control in, count/wrap and
//              display outputs out)
module seg7_scan_counter
  import seg7_scan_counter_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int PRESCALE       = 50000,
  parameter int SCAN_DIV       = 12500,
  parameter int BLANK_CYCLES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b0
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  seg7_scan_counter_if.slave  bus
);

  localparam int CNT_W  = BCD_W * NUM_DIGITS;
  localparam int PS_W   = (PRESCALE > 1)   ? $clog2(PRESCALE)   : 1;
  localparam int SLOT_W = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PS_W-1:0]       PS_LAST   = PS_W'(PRESCALE - 1);
  localparam logic [SLOT_W-1:0]     SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0]     BLANK_END = SLOT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SEG_W-1:0]      SEG_INV   = {SEG_W{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] SEL_INV   = {NUM_DIGITS{SEL_ACTIVE_LOW}};

  // ---------------------------------------------------------------- counter
  logic [CNT_W-1:0]  count_q;
  logic [PS_W-1:0]   presc_q;
  logic              wrap_q;

  logic [CNT_W-1:0]  load_clamped;
  logic [CNT_W-1:0]  count_step;
  logic [BCD_W-1:0]  cur;
  logic              carry;
  logic              all_nine;
  logic              all_zero;
  logic              wrap_cond;
  logic              step;
  cnt_op_e           op;

  always_comb begin
    load_clamped = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      load_clamped[BCD_W*i +: BCD_W] = bcd_clamp(bus.load_value[BCD_W*i +: BCD_W]);
    end
  end

  // Ripple the +1/-1 from digit 0 upward; a digit only changes while the
  // carry/borrow is still alive.
  always_comb begin
    count_step = count_q;
    cur        = '0;
    carry      = 1'b1;
    all_nine   = 1'b1;
    all_zero   = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      cur = count_q[BCD_W*i +: BCD_W];
      if (cur != 4'd9) all_nine = 1'b0;
      if (cur != 4'd0) all_zero = 1'b0;
      if (carry) begin
        if (bus.up_down) begin
          if (cur == 4'd9) begin
            count_step[BCD_W*i +: BCD_W] = 4'd0;
          end else begin
            count_step[BCD_W*i +: BCD_W] = cur + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (cur == 4'd0) begin
            count_step[BCD_W*i +: BCD_W] = 4'd9;
          end else begin
            count_step[BCD_W*i +: BCD_W] = cur - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    wrap_cond = bus.up_down ? all_nine : all_zero;
  end

  always_comb begin
    op   = OP_HOLD;
    step = !bus.inhibit && (presc_q == PS_LAST);
    if (bus.load) begin
      op = OP_LOAD;
    end else if (step) begin
      op = OP_STEP;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      count_q <= '0;
      presc_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      case (op)
        OP_LOAD: begin
          count_q <= load_clamped;
          presc_q <= '0;
        end
        OP_STEP: begin
          count_q <= count_step;
          presc_q <= '0;
          wrap_q  <= wrap_cond;
        end
        default: begin
          if (!bus.inhibit) presc_q <= presc_q + 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- scanner
  logic [SLOT_W-1:0]           slot_q;
  logic [SLOT_W-1:0]           slot_nxt;
  logic [IDX_W-1:0]            idx_q;
  logic [IDX_W-1:0]            idx_nxt;
  logic [NUM_DIGITS-1:0]       lead_zero;
  logic                        zero_run;
  logic [NUM_DIGITS-1:0]       sel_hot;
  logic [BCD_W-1:0]            scan_digit;
  logic                        scan_blank;
  logic [SEG_W-1:0]            scan_seg;
  logic [SEG_W-1:0]            seg_q;
  logic [NUM_DIGITS-1:0]       sel_q;
  logic [SEG_W*NUM_DIGITS-1:0] hex_dec;
  logic [SEG_W*NUM_DIGITS-1:0] hex_q;

  always_comb begin
    slot_nxt = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
    idx_nxt  = idx_q;
    if (slot_q == SLOT_LAST) begin
      idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // lead_zero[i]: digits i..NUM_DIGITS-1 are all zero.
  always_comb begin
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int unsigned k = NUM_DIGITS; k > 0; k--) begin
      zero_run       = zero_run && (count_q[BCD_W*(k-1) +: BCD_W] == 4'd0);
      lead_zero[k-1] = zero_run;
    end
  end

  // Output registers are loaded from the next slot/index so that seg/sel
  // always line up with the slot counter value they are registered against.
  always_comb begin
    sel_hot    = '0;
    scan_digit = '0;
    scan_blank = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_nxt == IDX_W'(i)) begin
        sel_hot[i] = 1'b1;
        scan_digit = count_q[BCD_W*i +: BCD_W];
        scan_blank = (i != 0) && bus.lzb_en && lead_zero[i];
      end
    end
  end

  seg7_decode u_scan_dec (
    .bcd (scan_digit),
    .seg (scan_seg)
  );

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_hex
    seg7_decode u_hex_dec (
      .bcd (count_q[BCD_W*g +: BCD_W]),
      .seg (hex_dec[SEG_W*g +: SEG_W])
    );
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      slot_q <= '0;
      idx_q  <= '0;
      sel_q  <= SEL_INV;
      seg_q  <= SEG_DARK ^ SEG_INV;
      hex_q  <= {NUM_DIGITS{SEG_0 ^ SEG_INV}};
    end else begin
      slot_q <= slot_nxt;
      idx_q  <= idx_nxt;
      if (slot_nxt < BLANK_END) begin
        sel_q <= SEL_INV;
        seg_q <= SEG_DARK ^ SEG_INV;
      end else begin
        sel_q <= sel_hot ^ SEL_INV;
        seg_q <= (scan_blank ? SEG_DARK : scan_seg) ^ SEG_INV;
      end
      hex_q <= hex_dec ^ {NUM_DIGITS{SEG_INV}};
    end
  end

  assign bus.count    = count_q;
  assign bus.wrap     = wrap_q;
  assign bus.seg      = seg_q;
  assign bus.sel      = sel_q;
  assign bus.hex_flat = hex_q;

endmodule

// File: tb/tb_seg7_scan_counter.sv
// Self-checking bench for seg7_scan_counter: decimal-integer reference model,
// table of load/run vectors, hand-written corner sequences and random traffic.
module tb_seg7_scan_counter;

  localparam int ND = 4;
  localparam int PS = 4;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int MODV = 10000;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;

  seg7_scan_counter_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_counter #(
    .NUM_DIGITS    (ND),
    .PRESCALE      (PS),
    .SCAN_DIV      (SD),
    .BLANK_CYCLES  (BC),
    .SEG_ACTIVE_LOW(1'b1),
    .SEL_ACTIVE_LOW(1'b0)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_pass   = 0;

  logic [6:0] pat [0:9];

  // reference model state
  int          m_cnt;
  int          m_presc;
  int          m_t;
  logic        m_wrap;
  logic [6:0]  m_seg;
  logic [3:0]  m_sel;
  logic [27:0] m_hex;

  typedef struct {
    string       name;
    logic [15:0] lv;
    logic        up;
    int          cycles;
    logic [15:0] exp_count;
    int          exp_wraps;
  } vec_t;

  vec_t vecs [6];

  function automatic int pow10(input int e);
    int r = 1;
    for (int k = 0; k < e; k++) r = r * 10;
    return r;
  endfunction

  function automatic int digit_of(input int v, input int i);
    return (v / pow10(i)) % 10;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'(digit_of(v, i));
    return r;
  endfunction

  function automatic int from_load(input logic [15:0] lv);
    int v = 0;
    int n;
    for (int i = 0; i < ND; i++) begin
      n = int'(lv[4*i +: 4]);
      if (n > 9) n = 9;
      v = v + n * pow10(i);
    end
    return v;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  function automatic void model_edge();
    int slot;
    int idx;
    if (reset) begin
      m_cnt = 0; m_presc = 0; m_wrap = 1'b0; m_t = 0;
      m_sel = 4'b0000; m_seg = 7'h7F;
      for (int i = 0; i < ND; i++) m_hex[7*i +: 7] = ~pat[0];
      return;
    end
    for (int i = 0; i < ND; i++) m_hex[7*i +: 7] = ~pat[digit_of(m_cnt, i)];
    m_t  = m_t + 1;
    slot = m_t % SD;
    idx  = (m_t / SD) % ND;
    if (slot < BC) begin
      m_sel = 4'b0000;
      m_seg = 7'h7F;
    end else begin
      m_sel = 4'(1 << idx);
      if (idx > 0 && bus.lzb_en && m_cnt < pow10(idx)) m_seg = 7'h7F;
      else m_seg = ~pat[digit_of(m_cnt, idx)];
    end
    m_wrap = 1'b0;
    if (bus.load) begin
      m_cnt   = from_load(bus.load_value);
      m_presc = 0;
    end else if (!bus.inhibit) begin
      if (m_presc == PS - 1) begin
        m_presc = 0;
        if (bus.up_down) begin
          m_wrap = (m_cnt == MODV - 1);
          m_cnt  = (m_cnt + 1) % MODV;
        end else begin
          m_wrap = (m_cnt == 0);
          m_cnt  = (m_cnt + MODV - 1) % MODV;
        end
      end else begin
        m_presc = m_presc + 1;
      end
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    model_edge();
    @(posedge CLOCK_50);
    #1;
    check("count", 64'(bus.count), 64'(to_bcd(m_cnt)));
    check("wrap", 64'(bus.wrap), 64'(m_wrap));
    check("seg", 64'(bus.seg), 64'(m_seg));
    check("sel", 64'(bus.sel), 64'(m_sel));
    check("hex_flat", 64'(bus.hex_flat), 64'(m_hex));
  endtask

  initial begin
    int wraps;
    int slot;
    int idx;
    logic [6:0] exp_seg;
    logic [3:0] exp_sel;

    pat[0] = 7'h3F; pat[1] = 7'h06; pat[2] = 7'h5B; pat[3] = 7'h4F; pat[4] = 7'h66;
    pat[5] = 7'h6D; pat[6] = 7'h7D; pat[7] = 7'h07; pat[8] = 7'h7F; pat[9] = 7'h6F;

    vecs[0] = '{name:"wrap_up", lv:16'h9998, up:1'b1, cycles:8, exp_count:16'h0000, exp_wraps:1};
    vecs[1] = '{name:"wrap_dn", lv:16'h0000, up:1'b0, cycles:4, exp_count:16'h9999, exp_wraps:1};
    vecs[2] = '{name:"clamp",   lv:16'h12AF, up:1'b1, cycles:0, exp_count:16'h1299, exp_wraps:0};
    vecs[3] = '{name:"carry",   lv:16'h0999, up:1'b1, cycles:4, exp_count:16'h1000, exp_wraps:0};
    vecs[4] = '{name:"borrow",  lv:16'h1000, up:1'b0, cycles:4, exp_count:16'h0999, exp_wraps:0};
    vecs[5] = '{name:"down2",   lv:16'h0042, up:1'b0, cycles:8, exp_count:16'h0040, exp_wraps:0};

    bus.inhibit = 1'b0; bus.up_down = 1'b1; bus.load = 1'b0;
    bus.load_value = '0; bus.lzb_en = 1'b0;
    reset = 1'b1;
    tick();
    tick();

    // reset state against fixed constants
    check("rst_count", 64'(bus.count), 64'h0);
    check("rst_wrap", 64'(bus.wrap), 64'h0);
    check("rst_sel", 64'(bus.sel), 64'h0);
    check("rst_seg", 64'(bus.seg), 64'h7F);
    check("rst_hex", 64'(bus.hex_flat), 64'({4{7'h40}}));

    // free run up from reset: 10 steps in 40 cycles
    reset = 1'b0;
    repeat (40) tick();
    check("up40_count", 64'(bus.count), 64'h0010);
    tick();
    check("up40_hex_d1", 64'(bus.hex_flat[13:7]), 64'(7'b1111001));
    check("up40_hex_d0", 64'(bus.hex_flat[6:0]), 64'(7'b1000000));

    // table of load / run vectors
    for (int v = 0; v < 6; v++) begin
      bus.load = 1'b1;
      bus.load_value = vecs[v].lv;
      bus.up_down = vecs[v].up;
      tick();
      bus.load = 1'b0;
      wraps = 0;
      for (int c = 0; c < vecs[v].cycles; c++) begin
        tick();
        if (bus.wrap === 1'b1) wraps++;
      end
      check({vecs[v].name, "_count"}, 64'(bus.count), 64'(vecs[v].exp_count));
      check({vecs[v].name, "_wraps"}, 64'(wraps), 64'(vecs[v].exp_wraps));
    end

    // inhibit mid-prescale freezes count and prescaler, scanner keeps going
    bus.up_down = 1'b1;
    bus.load = 1'b1; bus.load_value = 16'h0500;
    tick();
    bus.load = 1'b0;
    tick(); tick();
    bus.inhibit = 1'b1;
    repeat (20) tick();
    check("inh_count", 64'(bus.count), 64'h0500);
    bus.inhibit = 1'b0;
    tick();
    check("inh_resume1", 64'(bus.count), 64'h0500);
    tick();
    check("inh_resume2", 64'(bus.count), 64'h0501);

    // leading-zero blanking on 0007
    bus.inhibit = 1'b1; bus.lzb_en = 1'b1;
    bus.load = 1'b1; bus.load_value = 16'h0007;
    tick();
    bus.load = 1'b0;
    for (int c = 0; c < 32; c++) begin
      tick();
      slot = m_t % SD;
      idx  = (m_t / SD) % ND;
      if (slot < BC) begin
        exp_sel = 4'b0000; exp_seg = 7'h7F;
      end else begin
        exp_sel = 4'(1 << idx);
        exp_seg = (idx == 0) ? 7'h78 : 7'h7F;
      end
      check("lzb_sel", 64'(bus.sel), 64'(exp_sel));
      check("lzb_seg", 64'(bus.seg), 64'(exp_seg));
    end

    // reset in the middle of an active slot
    for (int c = 0; c < SD; c++) begin
      if (m_t % SD == 4) break;
      tick();
    end
    reset = 1'b1;
    tick();
    check("mid_rst_sel", 64'(bus.sel), 64'h0);
    check("mid_rst_count", 64'(bus.count), 64'h0);
    check("mid_rst_seg", 64'(bus.seg), 64'h7F);
    reset = 1'b0;
    tick();
    check("post_rst_blank_sel", 64'(bus.sel), 64'h0);
    tick();
    check("post_rst_sel", 64'(bus.sel), 64'h1);
    check("post_rst_seg", 64'(bus.seg), 64'h40);

    // random traffic against the model
    bus.inhibit = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      reset    = ($urandom_range(0, 299) == 0);
      bus.load = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 3))
        0:       bus.load_value = 16'h9997;
        1:       bus.load_value = 16'h0002;
        default: bus.load_value = 16'($urandom);
      endcase
      bus.inhibit = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 63) == 0) bus.up_down = ~bus.up_down;
      if ($urandom_range(0, 31) == 0) bus.lzb_en = ~bus.lzb_en;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_counter.md
Name: seg7_scan_counter

Overview:
Parametrised N-digit decimal (true BCD) up/down counter with prescaler, parallel load and wrap flag. It includes a time-multiplexed 7-segment scanner for a shared-segment display, with per-slot ghost blanking, optional leading-zero blanking and selectable output polarities. It also provides per-digit static segment codes for directly wired HEX displays. It sits between board clock/switches and the display GPIO/HEX pins.

Parameters:
NUM_DIGITS, 4, number of BCD digits and scan select lines (1..8)
PRESCALE, 50000, CLOCK_50 cycles per count step (>=1; 1 = step every cycle)
SCAN_DIV, 12500, cycles per digit scan slot (> BLANK_CYCLES)
BLANK_CYCLES, 64, cycles at start of each slot with display dark (0 = none)
SEG_ACTIVE_LOW, 1, 1 = segment lit when bit is 0 (applies to seg and hex_flat)
SEL_ACTIVE_LOW, 0, 1 = digit select asserted low

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
inhibit  in  1  1 = freeze counter and prescaler (scanner keeps running)
up_down  in  1  1 = count up, 0 = count down
load  in  1  1-cycle parallel load strobe
load_value  in  4*NUM_DIGITS  BCD load data, digit 0 in [3:0]
lzb_en  in  1  1 = blank leading zeros on the scanned display
count  out  4*NUM_DIGITS  current BCD value
wrap  out  1  1-cycle pulse on full-range wrap
seg  out  7  scanned segment bus {g,f,e,d,c,b,a}
sel  out  NUM_DIGITS  scanned one-hot digit select
hex_flat  out  7*NUM_DIGITS  static decoded segments, digit i in [7i+6:7i]

Behaviour:
- Reset state: count=0, prescaler=0, wrap=0, scan index=0, slot counter=0, sel all inactive, seg all dark, hex_flat = code of '0' for every digit.
- Prescaler: runs 0..PRESCALE-1. Step asserted on the cycle it equals PRESCALE-1 with inhibit=0; it then returns to 0. Holds its value while inhibit=1.
- Priority per cycle: reset > load > step > hold.
- load: count=load_value on the next edge, prescaler cleared, wrap=0. Any nibble >9 is loaded as 9. load acts even when inhibit=1.
- Step up: digit 0 increments. Digit 9->0 carries into the next digit. All digits 9 -> all 0, with wrap=1 for exactly that cycle.
- Step down: 0->9 borrows from the next digit. All digits 0 -> all 9, with wrap=1.
- Latency: count updates on the edge after the step cycle. hex_flat is registered, one cycle behind count.
- Scanner: slot counter runs 0..SCAN_DIV-1. Scan index advances mod NUM_DIGITS when the slot counter wraps. Scanner is independent of inhibit and load.
- Blank phase (slot counter < BLANK_CYCLES): sel all inactive, seg dark.
- Active phase: sel one-hot at the scan index; seg = registered decode of that digit.
- seg/sel are registered and change on the same edge, so they never show a mismatched digit/segment pair.
- Leading-zero blanking: digit i (i>0) shows dark when lzb_en=1 and digits i..NUM_DIGITS-1 are all 0. Digit 0 is never blanked, so a value of 0 shows a single '0'. LZB does not affect hex_flat.
- Decode: 0-9 standard patterns. Non-BCD nibbles cannot occur internally; the decoder maps them to dark.
- Polarity parameters invert at the output register only.
- Reset mid-slot: next cycle is the reset state, and the scan restarts at digit 0 beginning with its blank phase.

Decomposition:
- Shared include/package holds:
  - 7-segment pattern constants (0-9, dark) in active-high form
  - BCD digit width constant (4)
  - segment width constant (7)
- One sub-module, seg7_decode: combinational 4-bit BCD to 7-bit active-high segments, instantiated once for the scanner and NUM_DIGITS times for hex_flat.
- Counter, prescaler and scanner stay inline in seg7_scan_counter.

Test Plan:
Bench params: NUM_DIGITS=4, PRESCALE=4, SCAN_DIV=8, BLANK_CYCLES=2, SEG_ACTIVE_LOW=1, SEL_ACTIVE_LOW=0.
- Release reset, up_down=1, run 40 cycles -> count=0x0010 (10 steps, one per 4 cycles); hex_flat digit1 = ~'1' = 7'b1111001.
- load=1 with load_value=0x9998, then count up -> 0x9999, then 0x0000 with wrap=1 for 1 cycle only.
- load 0x0000, up_down=0 -> after one step count=0x9999 and wrap pulses.
- load_value=0x12AF -> count=0x1299 (nibbles clamped).
- inhibit=1 for 20 cycles mid-prescale -> count and prescaler frozen; sel keeps cycling 0001,0010,0100,1000 with 2 blank cycles (sel=0000, seg=7'h7F) per 8-cycle slot.
- count=0x0007, lzb_en=1 -> slots 1-3 show seg=7'h7F while their sel bit is high, slot 0 shows ~'7'. Assert reset mid-slot -> next cycle sel=0000, count=0.
